// File: rtl/fifo_16.sv
// Synchronous single-clock FIFO, DEPTH = 2**BUF_WIDTH words, with occupancy count and threshold flags.
// Latency: a word written at edge N is readable from edge N+1; buf_out is registered and updates on the read edge.
// Backpressure: a write into a full FIFO is dropped unless a read happens in the same cycle; a read from empty is ignored.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   buf_in, wr_en      write data and write request
//   rd_en, buf_out     read request and registered read data (holds when no read)
//   uH, uL             almost-full free-slot margin, almost-empty occupancy threshold
//   buf_empty/full, almost_full/empty, fifo_counter   status decoded from occupancy
module fifo_16 #(
  parameter int BUF_WIDTH  = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] uH,
  input  logic [DATA_WIDTH-1:0] uL,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int DEPTH = 1 << BUF_WIDTH;
  localparam int CW    = BUF_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_WIDTH-1:0]  wr_ptr;
  logic [BUF_WIDTH-1:0]  rd_ptr;
  logic                  we;
  logic                  re;
  logic [CW-1:0]         uh_ext;
  logic [CW-1:0]         ul_ext;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign we = wr_en & (~buf_full | rd_en);
  assign re = rd_en & ~buf_empty;

  // Thresholds are resized (zero-extend or truncate) to counter width.
  always_comb begin
    uh_ext       = CW'(uH);
    ul_ext       = CW'(uL);
    buf_empty    = (fifo_counter == '0);
    buf_full     = (fifo_counter == DEPTH_C);
    almost_empty = (fifo_counter <= ul_ext);
    // Guard the subtraction so a margin of DEPTH or more never wraps.
    if (uh_ext >= DEPTH_C) begin
      almost_full = 1'b1;
    end else begin
      almost_full = (fifo_counter >= (DEPTH_C - uh_ext));
    end
  end

  // Storage is not reset; reset only blocks a write on that edge.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wr_ptr] <= buf_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      buf_out      <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (re) begin
        buf_out <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({we, re})
        2'b10:   fifo_counter <= fifo_counter + 1'b1;
        2'b01:   fifo_counter <= fifo_counter - 1'b1;
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_16.sv
module tb_fifo_16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] buf_in;
  logic [3:0] uH;
  logic [3:0] uL;
  logic [3:0] buf_out;
  logic       buf_empty;
  logic       buf_full;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] fifo_counter;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a plain queue, last read word in exp_out.
  int q[$];
  int exp_out;

  always #5 clk = ~clk;

  fifo_16 #(.BUF_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .uH           (uH),
    .uL           (uL),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_counter (fifo_counter)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count", fifo_counter, n);
    check("empty", buf_empty, (n == 0));
    check("full", buf_full, (n == 16));
    check("almost_full", almost_full, ((n + int'(uH)) >= 16));
    check("almost_empty", almost_empty, (n <= int'(uL)));
    check("buf_out", buf_out, exp_out);
  endtask

  // Drive one cycle, advance the model on the same edge, then compare.
  task automatic step(input logic r, input logic w, input logic rd, input logic [3:0] d);
    bit full_m;
    bit empty_m;
    rst    = r;
    wr_en  = w;
    rd_en  = rd;
    buf_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_out = 0;
    end else begin
      full_m  = (q.size() == 16);
      empty_m = (q.size() == 0);
      if (rd && !empty_m) exp_out = q.pop_front();
      if (w && (!full_m || rd)) q.push_back(int'(d));
    end
    #1;
    check_all();
  endtask

  initial begin
    int wp;
    int rp;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0;
    uH = 4'd2; uL = 4'd3;
    exp_out = 0;

    // Reset with active write/read requests; reset wins.
    step(1'b1, 1'b1, 1'b1, 4'd5);
    check("rst_count", fifo_counter, 0);
    check("rst_empty", buf_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_out", buf_out, 0);

    // Simultaneous write and read with one entry present.
    step(1'b0, 1'b1, 1'b0, 4'd1);
    step(1'b0, 1'b1, 1'b1, 4'd2);
    check("wrrd_out", buf_out, 1);
    check("wrrd_count", fifo_counter, 1);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("wrrd_next", buf_out, 2);

    // Fill to full, watching threshold crossings.
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'(i));
      if (i == 3)  check("ae_at3", almost_empty, 1);
      if (i == 4)  check("ae_at4", almost_empty, 0);
      if (i == 13) check("af_at13", almost_full, 0);
      if (i == 14) check("af_at14", almost_full, 1);
      if (i == 15) check("full_at15", buf_full, 0);
      if (i == 16) check("full_at16", buf_full, 1);
    end
    step(1'b0, 1'b1, 1'b0, 4'd7);
    check("overflow_count", fifo_counter, 16);

    // Write+read on a full FIFO: oldest out, 9 joins at the tail.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    check("full_wrrd_out", buf_out, 1);
    check("full_wrrd_count", fifo_counter, 16);

    // Drain completely; the model checks order, last word must be 9.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 4'd0);
    check("drain_last", buf_out, 9);
    check("drain_empty", buf_empty, 1);
    step(1'b0, 1'b0, 1'b1, 4'd0);
    check("underflow_out", buf_out, 9);
    check("underflow_count", fifo_counter, 0);

    // Reset mid-operation, coincident with a read.
    step(1'b0, 1'b1, 1'b0, 4'd5);
    step(1'b1, 1'b0, 1'b1, 4'd0);
    check("midrst_count", fifo_counter, 0);
    check("midrst_out", buf_out, 0);
    check("midrst_empty", buf_empty, 1);

    // Randomized phases with varying write/read bias and thresholds.
    wp = 50; rp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        wp = $urandom_range(10, 90);
        rp = $urandom_range(10, 90);
        uH = 4'($urandom_range(0, 15));
        uL = 4'($urandom_range(0, 15));
      end
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wp),
           ($urandom_range(0, 99) < rp),
           4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
